// File: rtl/instr_stream_loader_pkg.sv
// Shared types and constants for the instruction stream loader.
package instr_stream_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR1,
    ST_WORD,
    ST_ISSUE,
    ST_GAP,
    ST_CHK,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CHK_WIDTH      = 8;

endpackage

// File: rtl/instr_stream_loader_if.sv
// Byte-stream input and processor manual-load signals of the instruction stream loader.
interface instr_stream_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] new_instruction;
  logic        add_into;
  logic        start_signal;
  logic        end_signal;
  logic [15:0] words_loaded;
  logic        load_done;
  logic        loader_error;

  // Host/processor side: supplies bytes and end_signal, observes the loader.
  modport master (
    output byte_valid, byte_data, end_signal,
    input  byte_ready, new_instruction, add_into, start_signal,
           words_loaded, load_done, loader_error
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data, end_signal,
    output byte_ready, new_instruction, add_into, start_signal,
           words_loaded, load_done, loader_error
  );
endinterface

// File: rtl/instr_stream_loader_byte_assembler.sv
// Little-endian 4-byte word assembler. word presents the assembled value with the
// byte currently being shifted in merged on top; word_full flags the byte that completes it.
module instr_stream_loader_byte_assembler
  import instr_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] shreg;
  logic [1:0]  idx;

  assign word      = {byte_in, shreg[31:8]};
  assign word_full = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

  // NOTE: non-blocking assignments keep every register update on the same edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (shift_en) begin
      shreg <= {byte_in, shreg[31:8]};
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_stream_loader.sv
// Frame loader: 16-bit LE word count, N little-endian words issued via add_into, then run.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_stream_loader
  import instr_stream_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned ISSUE_GAP = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_stream_loader_if.slave  bus
);

  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'((ISSUE_GAP == 0) ? 0 : ISSUE_GAP - 1);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t            state;
  logic              byte_ready;
  logic [31:0]       new_instruction;
  logic              add_into;
  logic              start_signal;
  logic [15:0]       words_loaded;
  logic              load_done;
  logic              loader_error;
  logic [15:0]       word_count;
  logic [7:0]        n_lo;
  logic [GAP_W-1:0]  gap_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [CHK_WIDTH-1:0] csum;
`endif

  logic        accept;
  logic [15:0] hdr_n;
  logic        gap_over;
  logic [31:0] asm_word;
  logic        asm_full;

  assign accept   = bus.byte_valid && byte_ready;
  assign hdr_n    = {bus.byte_data, n_lo};
  // With ISSUE_GAP == 0 the issue cycle itself decides what comes next.
  assign gap_over = ((state == ST_ISSUE) && (ISSUE_GAP == 0)) ||
                    ((state == ST_GAP) && (gap_cnt == '0));

  instr_stream_loader_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == ST_ISSUE),
    .shift_en  (accept && (state == ST_WORD)),
    .byte_in   (bus.byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  // byte_ready is registered, so every transition also sets its value for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      byte_ready      <= 1'b0;
      new_instruction <= '0;
      add_into        <= 1'b0;
      start_signal    <= 1'b0;
      words_loaded    <= '0;
      load_done       <= 1'b0;
      loader_error    <= 1'b0;
      word_count      <= '0;
      n_lo            <= '0;
      gap_cnt         <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum            <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          byte_ready <= 1'b1;
          if (accept) begin
            n_lo  <= bus.byte_data;
            state <= ST_HDR1;
          end
        end
        ST_HDR1: if (accept) begin
          word_count <= hdr_n;
          if (hdr_n == '0 || hdr_n > MAX_N) begin
            state        <= ST_ERROR;
            byte_ready   <= 1'b0;
            loader_error <= 1'b1;
          end else begin
            state <= ST_WORD;
          end
        end
        ST_WORD: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ bus.byte_data;
`endif
          if (asm_full) begin
            new_instruction <= asm_word;
            add_into        <= 1'b1;
            words_loaded    <= words_loaded + 16'd1;
            byte_ready      <= 1'b0;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          add_into <= 1'b0;
          if (ISSUE_GAP != 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_RELOAD;
          end
        end
        ST_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: if (accept) begin
          byte_ready <= 1'b0;
          if (bus.byte_data == csum) begin
            start_signal <= 1'b1;
            state        <= ST_RUN;
          end else begin
            loader_error <= 1'b1;
            state        <= ST_ERROR;
          end
        end
`endif
        ST_RUN: if (bus.end_signal) begin
          load_done <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE, ST_ERROR: ;
        default: state <= ST_IDLE;
      endcase

      if (gap_over) begin
        if (words_loaded < word_count) begin
          state      <= ST_WORD;
          byte_ready <= 1'b1;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state      <= ST_CHK;
          byte_ready <= 1'b1;
`else
          state        <= ST_RUN;
          start_signal <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.byte_ready      = byte_ready;
  assign bus.new_instruction = new_instruction;
  assign bus.add_into        = add_into;
  assign bus.start_signal    = start_signal;
  assign bus.words_loaded    = words_loaded;
  assign bus.load_done       = load_done;
  assign bus.loader_error    = loader_error;

endmodule
